// File: rtl/passcode_entry_controller_pkg.sv
// Shared types and constants for the passcode entry controller.
// State codes, display nibble codes and digit-count sizing.
package passcode_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ENTRY   = 3'd0;
    localparam state_t CHECK   = 3'd1;
    localparam state_t UNLOCK  = 3'd2;
    localparam state_t FAIL    = 3'd3;
    localparam state_t LOCKOUT = 3'd4;

    typedef logic [3:0] nibble_t;

    localparam nibble_t BLANK  = 4'hF;
    localparam nibble_t ACCEPT = 4'hA;
    localparam nibble_t ERROR  = 4'hE;

    localparam int CNT_W = 3;
    typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/passcode_entry_controller_if.sv
// Keypad-side and display-side signals of the passcode controller.
// master drives digits and pulses; slave is the controller.
interface passcode_entry_controller_if;
    import passcode_pkg::*;

    nibble_t    Digit_in;
    logic       Enter;
    logic       Clear;
    logic       Unlocked;
    logic       Locked_out;
    logic [1:0] Tries_left;
    nibble_t    Disp3;
    nibble_t    Disp2;
    nibble_t    Disp1;
    nibble_t    Disp0;

    modport master (
        output Digit_in, Enter, Clear,
        input  Unlocked, Locked_out, Tries_left,
        input  Disp3, Disp2, Disp1, Disp0
    );

    modport slave (
        input  Digit_in, Enter, Clear,
        output Unlocked, Locked_out, Tries_left,
        output Disp3, Disp2, Disp1, Disp0
    );

endinterface

// File: rtl/passcode_entry_controller_digit_shifter.sv
// Four-nibble entry register: shifts digits in from the right,
// counts them, and can be blanked or filled with one constant.
module passcode_digit_shifter
    import passcode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  nibble_t          load_val,
    input  logic             shift,
    input  nibble_t          digit,
    output nibble_t [3:0]    disp,
    output count_t           count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            disp  <= {4{BLANK}};
            count <= '0;
        end else if (load) begin
            disp  <= {4{load_val}};
            count <= '0;
        end else if (shift) begin
            disp  <= {disp[2:0], digit};
            count <= count + count_t'(1);
        end
    end

endmodule

// File: rtl/passcode_entry_controller.sv
// Passcode entry FSM: collects four BCD digits, checks them against
// CODE, and runs the unlock / error / lockout timed states.
module passcode_entry_controller
    import passcode_pkg::*;
#(
    parameter logic [15:0] CODE          = 16'h1234,
    parameter int          MAX_TRIES     = 3,
    parameter int          UNLOCK_CYCLES = 8,
    parameter int          FAIL_CYCLES   = 4,
    parameter int          LOCK_CYCLES   = 16
) (
    input  logic                        Clk,
    input  logic                        Rst,
    passcode_entry_controller_if.slave  bus
);

    localparam int T_UF  = (UNLOCK_CYCLES > FAIL_CYCLES) ?
                           UNLOCK_CYCLES : FAIL_CYCLES;
    localparam int T_MAX = (T_UF > LOCK_CYCLES) ? T_UF : LOCK_CYCLES;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef logic [TW-1:0] timer_t;

    generate
        if (UNLOCK_CYCLES < 1 || FAIL_CYCLES < 1 || LOCK_CYCLES < 1) begin : g_bad_cycles
            $error("timed state lengths must be at least 1 cycle");
        end
        if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_tries
            $error("MAX_TRIES must be 1..3");
        end
    endgenerate

    localparam logic [1:0] TRIES_FULL = 2'(MAX_TRIES);

    state_t     state, state_nx;
    timer_t     timer, timer_nx;
    logic [1:0] tries, tries_nx;
    logic       unlocked, locked_out;

    logic       sh_clear, sh_load, sh_shift;
    nibble_t    sh_val;
    nibble_t [3:0] disp;
    count_t     count;

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        tries_nx = tries;
        sh_clear = 1'b0;
        sh_load  = 1'b0;
        sh_val   = BLANK;
        sh_shift = 1'b0;
        case (state)
            ENTRY: begin
                if (count == count_t'(4)) begin
                    state_nx = CHECK;
                end else if (bus.Clear) begin
                    sh_clear = 1'b1;
                end else if (bus.Enter && bus.Digit_in <= 4'd9) begin
                    sh_shift = 1'b1;
                end
            end
            CHECK: begin
                sh_load = 1'b1;
                if (disp == CODE) begin
                    state_nx = UNLOCK;
                    timer_nx = timer_t'(UNLOCK_CYCLES - 1);
                    tries_nx = TRIES_FULL;
                    sh_val   = ACCEPT;
                end else if (tries > 2'd1) begin
                    state_nx = FAIL;
                    timer_nx = timer_t'(FAIL_CYCLES - 1);
                    tries_nx = tries - 2'd1;
                    sh_val   = ERROR;
                end else begin
                    state_nx = LOCKOUT;
                    timer_nx = timer_t'(LOCK_CYCLES - 1);
                    tries_nx = 2'd0;
                    sh_val   = ERROR;
                end
            end
            UNLOCK: begin
                if (timer == '0 || bus.Clear) begin
                    state_nx = ENTRY;
                    timer_nx = '0;
                    sh_clear = 1'b1;
                end else begin
                    timer_nx = timer - timer_t'(1);
                end
            end
            FAIL: begin
                if (timer == '0) begin
                    state_nx = ENTRY;
                    sh_clear = 1'b1;
                end else begin
                    timer_nx = timer - timer_t'(1);
                end
            end
            LOCKOUT: begin
                if (timer == '0) begin
                    state_nx = ENTRY;
                    tries_nx = TRIES_FULL;
                    sh_clear = 1'b1;
                end else begin
                    timer_nx = timer - timer_t'(1);
                end
            end
            default: begin
                state_nx = ENTRY;
                timer_nx = '0;
                sh_clear = 1'b1;
            end
        endcase
    end

    // Flags are registered from the next state so they track state exactly.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= ENTRY;
            timer      <= '0;
            tries      <= TRIES_FULL;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            tries      <= tries_nx;
            unlocked   <= (state_nx == UNLOCK);
            locked_out <= (state_nx == LOCKOUT);
        end
    end

    passcode_digit_shifter u_shift (
        .clk      (Clk),
        .rst      (Rst),
        .clear    (sh_clear),
        .load     (sh_load),
        .load_val (sh_val),
        .shift    (sh_shift),
        .digit    (bus.Digit_in),
        .disp     (disp),
        .count    (count)
    );

    assign bus.Unlocked   = unlocked;
    assign bus.Locked_out = locked_out;
    assign bus.Tries_left = tries;
    assign bus.Disp3      = disp[3];
    assign bus.Disp2      = disp[2];
    assign bus.Disp1      = disp[1];
    assign bus.Disp0      = disp[0];

endmodule
